// File: rtl/rtc_bus_sequencer_if.sv
// rtl/rtc_bus_sequencer_if.sv - request handshake and multiplexed A/D bus signals (burst_len only with RTC_BUS_BURST_EN)
interface rtc_bus_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic [DATA_W-1:0] bus_in;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic              A_D;
   logic              CS;
   logic              WR;
   logic              RD;
   logic              ready;
   logic              done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
`ifdef RTC_BUS_BURST_EN
   logic [3:0]        burst_len;

   // master: control FSM and pad read path; slave: the sequencer
   modport master (
      output start, rw, addr, wr_data, bus_in, burst_len,
      input  wr_ack, bus_out, bus_oe, A_D, CS, WR, RD, ready, done, rd_data, rd_valid
   );
   modport slave (
      input  start, rw, addr, wr_data, bus_in, burst_len,
      output wr_ack, bus_out, bus_oe, A_D, CS, WR, RD, ready, done, rd_data, rd_valid
   );
`else
   // master: control FSM and pad read path; slave: the sequencer
   modport master (
      output start, rw, addr, wr_data, bus_in,
      input  wr_ack, bus_out, bus_oe, A_D, CS, WR, RD, ready, done, rd_data, rd_valid
   );
   modport slave (
      input  start, rw, addr, wr_data, bus_in,
      output wr_ack, bus_out, bus_oe, A_D, CS, WR, RD, ready, done, rd_data, rd_valid
   );
`endif
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - counted address/data bus-cycle sequencer for the V3023 RTC (burst option: RTC_BUS_BURST_EN)
module rtc_bus_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 8,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 4
) (
   input  logic               Clock_in,
   input  logic               Reset,
   rtc_bus_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_SETUP,
      S_ADDR_STROBE,
      S_ADDR_HOLD,
      S_GAP,
      S_DATA_SETUP,
      S_DATA_STROBE,
      S_DATA_HOLD,
      S_DONE
   } state_t;

   // counter reload values: each phase counts down from width-1 to 0
   localparam logic [7:0] L_SETUP = 8'(T_SETUP - 1);
   localparam logic [7:0] L_PULSE = 8'(T_PULSE - 1);
   localparam logic [7:0] L_HOLD  = 8'(T_HOLD - 1);
   localparam logic [7:0] L_GAP   = 8'(T_GAP - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_cnt;
   logic [7:0]        w_load;
   logic              w_last;
   logic              w_more;
   logic              w_inter;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

`ifdef RTC_BUS_BURST_EN
   logic [3:0]        r_burst;
   logic              r_inter;

   assign w_more  = (r_burst != 4'd0);
   assign w_inter = r_inter;
`else
   assign w_more  = 1'b0;
   assign w_inter = 1'b0;
`endif

   assign w_last = (r_cnt == 8'd0);

   // state register; reset abandons any transaction in flight
   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // phase sequencing; a GAP between burst accesses returns to the address phase
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:        if (bus.start) w_state_next = S_ADDR_SETUP;
         S_ADDR_SETUP:  if (w_last) w_state_next = S_ADDR_STROBE;
         S_ADDR_STROBE: if (w_last) w_state_next = S_ADDR_HOLD;
         S_ADDR_HOLD:   if (w_last) w_state_next = S_GAP;
         S_GAP:         if (w_last) w_state_next = w_inter ? S_ADDR_SETUP : S_DATA_SETUP;
         S_DATA_SETUP:  if (w_last) w_state_next = S_DATA_STROBE;
         S_DATA_STROBE: if (w_last) w_state_next = S_DATA_HOLD;
         S_DATA_HOLD:   if (w_last) w_state_next = w_more ? S_GAP : S_DONE;
         S_DONE:        w_state_next = S_IDLE;
         default:       w_state_next = S_IDLE;
      endcase
   end

   // reload value for the phase being entered
   always_comb begin
      w_load = 8'd0;
      case (w_state_next)
         S_ADDR_SETUP, S_DATA_SETUP:   w_load = L_SETUP;
         S_ADDR_STROBE, S_DATA_STROBE: w_load = L_PULSE;
         S_ADDR_HOLD, S_DATA_HOLD:     w_load = L_HOLD;
         S_GAP:                        w_load = L_GAP;
         default:                      w_load = 8'd0;
      endcase
   end

   // phase counter: reload on every state change, otherwise count down to zero
   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset)                       r_cnt <= 8'd0;
      else if (w_state_next != r_state) r_cnt <= w_load;
      else if (!w_last)                r_cnt <= r_cnt - 8'd1;
   end

   // request latch; bursts step the address between accesses
   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         r_rw    <= 1'b0;
         r_addr  <= '0;
`ifdef RTC_BUS_BURST_EN
         r_burst <= 4'd0;
         r_inter <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_rw    <= bus.rw;
            r_addr  <= bus.addr;
`ifdef RTC_BUS_BURST_EN
            r_burst <= bus.burst_len;
`endif
         end
`ifdef RTC_BUS_BURST_EN
         if (r_state == S_DATA_HOLD && w_state_next == S_GAP) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_burst <= r_burst - 4'd1;
            r_inter <= 1'b1;
         end
         if (r_state == S_GAP && w_state_next == S_ADDR_SETUP) r_inter <= 1'b0;
`endif
      end
   end

   // write word taken on the edge entering DATA_SETUP; read word on the edge leaving DATA_STROBE
   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == S_GAP && w_state_next == S_DATA_SETUP) r_wdata <= bus.wr_data;
         if (r_state == S_DATA_STROBE && w_last && r_rw)       r_rdata <= bus.bus_in;
      end
   end

   // pad controls decoded from state so reset reaches the pins without a clock edge
   always_comb begin
      bus.A_D      = 1'b1;
      bus.CS       = 1'b1;
      bus.WR       = 1'b1;
      bus.RD       = 1'b1;
      bus.bus_oe   = 1'b0;
      bus.bus_out  = '0;
      bus.ready    = 1'b0;
      bus.done     = 1'b0;
      bus.wr_ack   = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = r_rdata;
      case (r_state)
         S_IDLE: bus.ready = 1'b1;
         S_ADDR_SETUP, S_ADDR_HOLD: begin
            bus.A_D     = 1'b0;
            bus.bus_oe  = 1'b1;
            bus.bus_out = DATA_W'(r_addr);
         end
         S_ADDR_STROBE: begin
            // address is always strobed with WR, even for a read
            bus.A_D     = 1'b0;
            bus.bus_oe  = 1'b1;
            bus.bus_out = DATA_W'(r_addr);
            bus.CS      = 1'b0;
            bus.WR      = 1'b0;
         end
         S_DATA_SETUP: begin
            bus.wr_ack = (r_cnt == L_SETUP);
            if (!r_rw) begin
               bus.bus_oe  = 1'b1;
               bus.bus_out = r_wdata;
            end
         end
         S_DATA_STROBE: begin
            bus.CS = 1'b0;
            if (r_rw) begin
               bus.RD = 1'b0;
            end else begin
               bus.WR      = 1'b0;
               bus.bus_oe  = 1'b1;
               bus.bus_out = r_wdata;
            end
         end
         S_DATA_HOLD: begin
            if (r_rw) begin
               bus.rd_valid = (r_cnt == L_HOLD);
            end else begin
               bus.bus_oe  = 1'b1;
               bus.bus_out = r_wdata;
            end
         end
         S_DONE:  bus.done = 1'b1;
         default: bus.ready = 1'b0;
      endcase
   end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised bus-cycle sequencer for the V3023 RTC multiplexed address/data bus. It replaces the fixed-timestamp write/read sequence with an internally counted state machine. Every phase width is a parameter, and a start/ready/done handshake selects a read or a write per transaction. It sits between the RTC control FSM and the pad-level tristate buffers on the shared A/D bus.

## Interface
Parameters:
- ADDR_W, 8, address width driven in the address phase
- DATA_W, 8, data width (must be ≥ ADDR_W); bus width = DATA_W
- T_SETUP, 2, cycles A_D is valid before the strobe falls (1..255)
- T_PULSE, 8, strobe (CS with WR or RD) low width in cycles (1..255)
- T_HOLD, 2, cycles the bus is held after the strobe rises (1..255)
- T_GAP, 4, idle cycles between the address phase and the data phase (1..255)

Ports:
- Clock_in  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high
- start  in  1  transaction request; sampled only when ready=1
- rw  in  1  1=read, 0=write; latched with start
- addr  in  ADDR_W  register address; latched with start
- wr_data  in  DATA_W  write word; sampled on entry to DATA_SETUP
- wr_ack  out  1  high for the first cycle of each DATA_SETUP
- bus_in  in  DATA_W  bus read path from pads
- bus_out  out  DATA_W  bus drive value (address zero-extended)
- bus_oe  out  1  tristate enable for bus_out
- A_D  out  1  0=address phase, 1=data phase
- CS  out  1  chip select, active low
- WR  out  1  write strobe, active low
- RD  out  1  read strobe, active low
- ready  out  1  idle; start is accepted
- done  out  1  one-cycle pulse at end of transaction
- rd_data  out  DATA_W  captured read word
- rd_valid  out  1  one-cycle pulse when rd_data updates

## Operation
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE. An 8-bit phase counter reloads on every state change.
- IDLE: ready=1. On start=1, latch rw and addr, then go to ADDR_SETUP.
- ADDR_SETUP (T_SETUP cycles): A_D=0, bus_oe=1, bus_out=addr.
- ADDR_STROBE (T_PULSE cycles): same as ADDR_SETUP, plus CS=0 and WR=0. The address phase always uses WR, in both modes.
- ADDR_HOLD (T_HOLD cycles): CS=1, WR=1; A_D=0 and bus still driven.
- GAP (T_GAP cycles): A_D=1, bus_oe=0.
- DATA_SETUP (T_SETUP cycles): A_D=1. For a write, bus_oe=1 and bus_out=wr_data, sampled on the entry edge.
- DATA_STROBE (T_PULSE cycles): CS=0, with WR=0 for a write or RD=0 for a read. For a read, bus_in is captured on the edge that leaves DATA_STROBE.
- DATA_HOLD (T_HOLD cycles): strobes high. A write keeps the bus driven. A read has bus_oe=0, rd_valid=1 in the first cycle, and rd_data holds the capture.
- DONE (1 cycle): done=1, then go to IDLE.
- Within one transaction, RD and WR are never low together. CS never goes low while bus_oe is changing.
- start while ready=0 is ignored. rd_data holds its value until the next read capture.

## Timing
- Reset values: A_D=1, CS=1, WR=1, RD=1, bus_oe=0, bus_out=0, ready=1, done=0, wr_ack=0, rd_valid=0, rd_data=0. State=IDLE.
- Reset asserts asynchronously at any point, including mid-strobe. All outputs take their reset values immediately and the transaction is discarded.
- Let the start edge be k. ADDR_SETUP begins at cycle k+1.
- done is high in cycle k+1+2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP. With the defaults this is k+29.
- The earliest next accepted start is the cycle after done.

## Configuration
- Macro: RTC_BUS_BURST_EN.
- Defined:
  - Adds input burst_len[3:0], latched with start, giving the number of additional accesses.
  - After DATA_HOLD, if accesses remain, go GAP → ADDR_SETUP with addr+1, wrapping mod 2^ADDR_W.
  - Each access has its own wr_ack, and its own rd_valid for reads.
  - done pulses once, after the final DATA_HOLD.
- Undefined: the port is absent and every transaction is a single access.

## Test plan
- Single write, defaults, addr=0x21, wr_data=0x5A, start at k:
  - A_D=0 and bus_out=0x21 for k+1..k+12; CS=WR=0 for k+3..k+10.
  - bus_out=0x5A with A_D=1 for k+17..k+28; CS=WR=0 for k+19..k+26; RD stays 1.
  - done at k+29.
- Single read, addr=0x05, bus_in=0xC3 during the strobe: RD=0 for k+19..k+26, bus_oe=0 from k+13, rd_data=0xC3 with rd_valid at k+27, done at k+29.
- start held high for the whole transaction: exactly one transaction runs, and a second is accepted only at k+30.
- Reset pulse at k+5, mid address strobe: CS, WR, A_D and ready go to 1 and bus_oe to 0 with no clock edge. After release the sequencer is idle.
- Burst (RTC_BUS_BURST_EN), write, burst_len=2, addr=0xFF: addresses 0xFF, 0x00, 0x01, each followed by one data phase; three wr_ack pulses; a single done at k+93.
- Non-default parameters T_SETUP=1, T_PULSE=1, T_HOLD=1, T_GAP=1, read: done at k+8, with RD low only in cycle k+6.
